// File: rtl/buzzer_melody_sequencer.sv
// Plays an 8-entry note table (C4..B4, rest) as a square wave with a silent gap after each entry.
// Start-to-busy latency is 1 cycle, all outputs are registered, and there is no backpressure (start while busy is dropped).
module buzzer_melody_sequencer #(
    parameter int CLK_HZ     = 100000000,
    parameter int NOTE_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic [2:0] note_idx
);

    localparam int HALF_MAX = CLK_HZ / (2 * 261);
    localparam int TW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int DUR_MAX  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DW       = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dur_q, dur_d;
    logic [TW-1:0]   tone_q, tone_d;
    logic            buzz_q, buzz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   half_m1;

    // Terminal value of the pitch counter (HALF-1) for each table entry.
    function automatic logic [TW-1:0] half_last(input logic [2:0] idx);
        case (idx)
            3'd0:    return TW'(CLK_HZ / (2 * 261) - 1);
            3'd1:    return TW'(CLK_HZ / (2 * 294) - 1);
            3'd2:    return TW'(CLK_HZ / (2 * 329) - 1);
            3'd3:    return TW'(CLK_HZ / (2 * 349) - 1);
            3'd4:    return TW'(CLK_HZ / (2 * 392) - 1);
            3'd5:    return TW'(CLK_HZ / (2 * 440) - 1);
            3'd6:    return TW'(CLK_HZ / (2 * 493) - 1);
            default: return '0;
        endcase
    endfunction

    assign half_m1 = half_last(idx_q);

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        buzz_d  = buzz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                buzz_d = 1'b0;
                busy_d = 1'b0;
                dur_d  = '0;
                tone_d = '0;
                if (start && !stop) begin
                    state_d = S_TONE;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                end
            end
            S_TONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    buzz_d  = 1'b0;
                    idx_d   = 3'd0;
                    dur_d   = '0;
                    tone_d  = '0;
                end else if (dur_q == DW'(NOTE_TICKS - 1)) begin
                    state_d = S_GAP;
                    dur_d   = '0;
                    tone_d  = '0;
                    buzz_d  = 1'b0;
                end else begin
                    dur_d = dur_q + DW'(1);
                    if (idx_q == 3'd7) begin
                        buzz_d = 1'b0;
                        tone_d = '0;
                    end else if (tone_q == half_m1) begin
                        tone_d = '0;
                        buzz_d = ~buzz_q;
                    end else begin
                        tone_d = tone_q + TW'(1);
                    end
                end
            end
            S_GAP: begin
                buzz_d = 1'b0;
                tone_d = '0;
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = 3'd0;
                    dur_d   = '0;
                end else if (dur_q == DW'(GAP_TICKS - 1)) begin
                    dur_d = '0;
                    if (idx_q != 3'd7) begin
                        state_d = S_TONE;
                        idx_d   = idx_q + 3'd1;
                    end else if (loop_en) begin
                        state_d = S_TONE;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end
                end else begin
                    dur_d = dur_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                buzz_d  = 1'b0;
                idx_d   = 3'd0;
                dur_d   = '0;
                tone_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dur_q   <= '0;
            tone_q  <= '0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            buzz_q  <= buzz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign buzzer   = buzz_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = idx_q;

endmodule

// File: tb/tb_buzzer_melody_sequencer.sv
// Directed bench for buzzer_melody_sequencer with a 10 kHz clock, 100-cycle notes and 10-cycle gaps.
module tb_buzzer_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop_en;
    logic       buzzer, busy, done;
    logic [2:0] note_idx;

    int n_vec = 0;
    int n_err = 0;

    buzzer_melody_sequencer #(
        .CLK_HZ     (10000),
        .NOTE_TICKS (100),
        .GAP_TICKS  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .buzzer   (buzzer),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {busy, done, note_idx, buzzer};
    endfunction

    // Hand-derived half periods: floor(10000 / (2*f)).
    function automatic int half_tab(input int idx);
        case (idx)
            0: return 19;
            1: return 17;
            2: return 15;
            3: return 14;
            4: return 12;
            5: return 11;
            default: return 10;
        endcase
    endfunction

    // Expected {busy,done,idx,buzzer} at cycle c after the start edge (c=1 is the first TONE cycle).
    function automatic logic [5:0] exp_at(input int c, input bit lp);
        int cc, idx, pos;
        logic bz;
        if (!lp && c > 880) return (c == 881) ? 6'b010000 : 6'b000000;
        cc  = lp ? ((c - 1) % 880) + 1 : c;
        idx = (cc - 1) / 110;
        pos = (cc - 1) % 110;
        bz  = 1'b0;
        if (pos < 100 && idx < 7) bz = ((pos / half_tab(idx)) % 2) == 1;
        return {1'b1, 1'b0, 3'(idx), bz};
    endfunction

    task automatic chk_cyc(input int c, input bit lp);
        chk($sformatf("seq c=%0d", c), 32'(obs()), 32'(exp_at(c, lp)));
    endtask

    task automatic play_check(input int lo, input int hi, input bit lp);
        for (int c = lo; c <= hi; c++) begin
            step();
            chk_cyc(c, lp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", 32'(obs()), 32'd0);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_cyc(1, loop_en);
    endtask

    initial begin
        int  first_rise;
        bit  seen_done;

        // One-shot pass with pitch tracking on idx 0.
        do_reset();
        kick();
        first_rise = -1;
        for (int c = 2; c <= 885; c++) begin
            step();
            chk_cyc(c, 1'b0);
            if (first_rise < 0 && buzzer === 1'b1) first_rise = c;
        end
        chk("first_rise", 32'(first_rise), 32'd20);

        // Looped playback across two full passes, then stop.
        do_reset();
        loop_en = 1'b1;
        kick();
        play_check(2, 1800, 1'b1);
        loop_en = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_stop", 32'(obs()), 32'd0);

        // Abort mid-note then replay from idx 0.
        do_reset();
        kick();
        play_check(2, 350, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_idle", 32'(obs()), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        chk("quiet_after_stop", 32'(seen_done), 32'd0);
        kick();
        play_check(2, 120, 1'b0);

        // Start held for 5 cycles acts as one start.
        do_reset();
        start = 1'b1;
        step();
        chk_cyc(1, 1'b0);
        play_check(2, 5, 1'b0);
        start = 1'b0;
        play_check(6, 890, 1'b0);

        // Simultaneous start and stop in IDLE.
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", 32'(obs()), 32'd0);
        step();
        chk("start_stop_idle2", 32'(obs()), 32'd0);

        // Synchronous reset mid-playback.
        do_reset();
        kick();
        play_check(2, 500, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid", 32'(obs()), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 900; i++) begin
            step();
            if (obs() !== 6'd0) seen_done = 1'b1;
        end
        chk("quiet_after_rst", 32'(seen_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
